// File: rtl/pwm_cmd_sched.sv
// Setpoint scheduler in front of the PWM generator: arbitrates software/auto
// commands, clamps them, and applies them at period boundaries with slew limiting and a watchdog.
module pwm_cmd_sched #(
    parameter int CW  = 24,
    parameter int WDW = 8
) (
    input  logic          axi_clk,
    input  logic          axi_rst,
    input  logic          enable_i,
    input  logic          period_start_i,
    input  logic [CW-1:0] neutral_0_i,
    input  logic [CW-1:0] neutral_1_i,
    input  logic [CW-1:0] min_i,
    input  logic [CW-1:0] max_i,
    input  logic [CW-1:0] slew_step_i,
    input  logic [WDW-1:0] timeout_i,
    input  logic          sw_override_i,
    input  logic          sw_valid_i,
    output logic          sw_ready_o,
    input  logic [CW-1:0] sw_active_0_i,
    input  logic [CW-1:0] sw_active_1_i,
    input  logic          auto_valid_i,
    output logic          auto_ready_o,
    input  logic [CW-1:0] auto_active_0_i,
    input  logic [CW-1:0] auto_active_1_i,
    output logic          pwm_enable_o,
    output logic [CW-1:0] pwm_active_0_o,
    output logic [CW-1:0] pwm_active_1_o,
    output logic          failsafe_o,
    output logic [1:0]    src_o,
    output logic [15:0]   update_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_FAILSAFE = 2'd2
    } state_e;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_SW   = 2'd1;
    localparam logic [1:0] SRC_AUTO = 2'd2;

    // An inverted window (lo > hi) collapses to the upper bound.
    function automatic logic [CW-1:0] clamp(
        input logic [CW-1:0] v,
        input logic [CW-1:0] lo,
        input logic [CW-1:0] hi
    );
        if (lo > hi)
            return hi;
        else if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    function automatic logic [CW-1:0] slew_toward(
        input logic [CW-1:0] cur,
        input logic [CW-1:0] tgt,
        input logic [CW-1:0] step
    );
        logic [CW:0] diff;
        logic        up;
        up   = (tgt >= cur);
        diff = up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
        if ((step == '0) || (diff <= {1'b0, step}))
            return tgt;
        else if (up)
            return cur + step;
        else
            return cur - step;
    endfunction

    state_e         state_q;
    logic [CW-1:0]  tgt_0_q, tgt_1_q;
    logic [CW-1:0]  out_0_q, out_1_q;
    logic [WDW-1:0] wd_cnt_q;
    logic           pwm_en_q;
    logic           failsafe_q;
    logic [1:0]     src_q;
    logic [15:0]    upd_cnt_q;

    logic           active;
    logic           sw_xfer, auto_xfer, xfer;
    logic [1:0]     xfer_src;
    logic [CW-1:0]  cmd_0_d, cmd_1_d;
    logic [CW-1:0]  neu_0_d, neu_1_d;
    logic [WDW-1:0] wd_cnt_d;
    logic           timeout_hit;

    assign active       = (state_q != ST_IDLE);
    assign sw_ready_o   = active && sw_override_i;
    assign auto_ready_o = active && !sw_override_i;

    assign sw_xfer   = sw_valid_i && sw_ready_o;
    assign auto_xfer = auto_valid_i && auto_ready_o;
    assign xfer      = sw_xfer || auto_xfer;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        xfer_src = SRC_NONE;
        cmd_0_d  = clamp(auto_active_0_i, min_i, max_i);
        cmd_1_d  = clamp(auto_active_1_i, min_i, max_i);
        if (sw_xfer) begin
            xfer_src = SRC_SW;
            cmd_0_d  = clamp(sw_active_0_i, min_i, max_i);
            cmd_1_d  = clamp(sw_active_1_i, min_i, max_i);
        end else if (auto_xfer) begin
            xfer_src = SRC_AUTO;
        end
    end

    assign neu_0_d = clamp(neutral_0_i, min_i, max_i);
    assign neu_1_d = clamp(neutral_1_i, min_i, max_i);

    // Watchdog counts whole periods and saturates rather than wrapping.
    assign wd_cnt_d    = (period_start_i && (wd_cnt_q != '1)) ? wd_cnt_q + 1'b1 : wd_cnt_q;
    assign timeout_hit = (timeout_i != '0) && (wd_cnt_d >= timeout_i);

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state_q    <= ST_IDLE;
            tgt_0_q    <= '0;
            tgt_1_q    <= '0;
            out_0_q    <= '0;
            out_1_q    <= '0;
            wd_cnt_q   <= '0;
            pwm_en_q   <= 1'b0;
            failsafe_q <= 1'b0;
            src_q      <= SRC_NONE;
            upd_cnt_q  <= '0;
        end else if (!enable_i) begin
            state_q    <= ST_IDLE;
            pwm_en_q   <= 1'b0;
            failsafe_q <= 1'b0;
            wd_cnt_q   <= '0;
            tgt_0_q    <= neu_0_d;
            tgt_1_q    <= neu_1_d;
            out_0_q    <= neu_0_d;
            out_1_q    <= neu_1_d;
            // Readys were still high this cycle, so a completed handshake is still counted.
            if (xfer) begin
                src_q     <= xfer_src;
                upd_cnt_q <= upd_cnt_q + 16'd1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q  <= ST_RUN;
                    pwm_en_q <= 1'b1;
                    wd_cnt_q <= '0;
                    tgt_0_q  <= neu_0_d;
                    tgt_1_q  <= neu_1_d;
                    out_0_q  <= neu_0_d;
                    out_1_q  <= neu_1_d;
                end
                ST_RUN, ST_FAILSAFE: begin
                    pwm_en_q <= 1'b1;
                    if (period_start_i) begin
                        out_0_q <= slew_toward(out_0_q, tgt_0_q, slew_step_i);
                        out_1_q <= slew_toward(out_1_q, tgt_1_q, slew_step_i);
                    end
                    if (xfer) begin
                        state_q    <= ST_RUN;
                        failsafe_q <= 1'b0;
                        tgt_0_q    <= cmd_0_d;
                        tgt_1_q    <= cmd_1_d;
                        src_q      <= xfer_src;
                        upd_cnt_q  <= upd_cnt_q + 16'd1;
                        wd_cnt_q   <= '0;
                    end else if (state_q == ST_RUN) begin
                        wd_cnt_q <= wd_cnt_d;
                        if (timeout_hit) begin
                            state_q    <= ST_FAILSAFE;
                            failsafe_q <= 1'b1;
                            tgt_0_q    <= neu_0_d;
                            tgt_1_q    <= neu_1_d;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    pwm_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_enable_o   = pwm_en_q;
    assign pwm_active_0_o = out_0_q;
    assign pwm_active_1_o = out_1_q;
    assign failsafe_o     = failsafe_q;
    assign src_o          = src_q;
    assign update_cnt_o   = upd_cnt_q;

endmodule

// File: doc/pwm_cmd_sched.md
Name: pwm_cmd_sched

Overview:
- Scheduler/arbiter sitting between command sources and the PWM generator's active-width inputs.
- Arbitrates drive/steer setpoints between a software requester and an autonomous requester (e.g. video-driven control), each with a valid/ready handshake.
- Clamps accepted setpoints and applies them only at PWM period boundaries, with per-period slew limiting.
- A period-counting watchdog falls back to neutral setpoints when no command arrives in time.

Parameters:
CW, 24, width of PWM counters and setpoint values
WDW, 8, width of watchdog timeout and watchdog counter

Ports:
axi_clk  in  1  system clock
axi_rst  in  1  reset, asynchronous, active-high
enable_i  in  1  block enable
period_start_i  in  1  one-cycle pulse from PWM generator at each period start
neutral_0_i  in  CW  neutral setpoint, channel 0 (drive)
neutral_1_i  in  CW  neutral setpoint, channel 1 (steer)
min_i  in  CW  clamp lower bound, both channels
max_i  in  CW  clamp upper bound, both channels
slew_step_i  in  CW  max output change per period; 0 = unlimited
timeout_i  in  WDW  watchdog limit in periods; 0 = watchdog disabled
sw_override_i  in  1  1 = software source selected, 0 = auto source selected
sw_valid_i  in  1  software command valid
sw_ready_o  out  1  software command ready
sw_active_0_i  in  CW  software setpoint, channel 0
sw_active_1_i  in  CW  software setpoint, channel 1
auto_valid_i  in  1  auto command valid
auto_ready_o  out  1  auto command ready
auto_active_0_i  in  CW  auto setpoint, channel 0
auto_active_1_i  in  CW  auto setpoint, channel 1
pwm_enable_o  out  1  enable to PWM generator
pwm_active_0_o  out  CW  applied active width, channel 0
pwm_active_1_o  out  CW  applied active width, channel 1
failsafe_o  out  1  1 while in FAILSAFE
src_o  out  2  source of last accepted command: 0 none, 1 sw, 2 auto
update_cnt_o  out  16  accepted command count, wraps 0xFFFF -> 0

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, targets 0, watchdog counter 0.
- States: IDLE, RUN, FAILSAFE.
  - Any state -> IDLE when enable_i = 0 (highest priority).
  - IDLE -> RUN when enable_i = 1.
  - RUN -> FAILSAFE when timeout_i != 0 and wd_cnt reaches timeout_i.
  - FAILSAFE -> RUN on any accepted transfer.
- IDLE:
  - pwm_enable_o = 0; both readys = 0; wd_cnt = 0.
  - Targets and outputs load clamp(neutral) every cycle, taking effect 1 cycle later.
- RUN/FAILSAFE:
  - pwm_enable_o = 1.
  - sw_ready_o = sw_override_i; auto_ready_o = !sw_override_i. The non-selected source is back-pressured.
  - Transfer occurs when valid & ready.
  - On transfer: targets <= clamp(setpoints) on the next edge; src_o updated; update_cnt_o incremented; wd_cnt cleared.
  - Multiple transfers within one period: the last one wins.
- clamp(v): v < min_i -> min_i; otherwise v > max_i -> max_i; otherwise v. If min_i > max_i the result is max_i.
- At a period_start_i edge, each channel output steps toward the target register value held before that edge:
  - If slew_step_i = 0 or |target - out| <= slew_step_i: out <= target.
  - Otherwise out <= out ± slew_step_i.
  - Difference computed in CW+1 bits; no wrap.
- Latency: transfer in cycle t -> target valid at t+1 -> output changes on the first period_start_i sampled at t+1 or later. A transfer coinciding with period_start_i does not affect that period.
- Watchdog:
  - In RUN, wd_cnt increments on each period_start_i and saturates at all-ones.
  - Entry to FAILSAFE: targets <= clamp(neutral); failsafe_o = 1 from the next cycle.
  - Outputs then slew to neutral at period boundaries.
- Simultaneous transfer and timeout in the same cycle: the transfer wins, wd_cnt is cleared, and no FAILSAFE entry occurs.
- Changing sw_override_i does not alter targets or wd_cnt. A valid held on the previously selected source is simply not accepted.
- Changing neutral/min/max mid-run affects only subsequent loads.

Test Plan:
- Enable with neutral_0 = 1500, neutral_1 = 1400, min = 1000, max = 2000 -> 1 cycle later pwm_enable_o = 1; outputs 1500/1400 after the next period_start.
- sw_override = 1, sw command 1800/1200, slew = 0 -> sw_ready = 1, auto_ready = 0; outputs 1800/1200 at the next period_start; src_o = 1; update_cnt_o = 1.
- slew = 100, target 1500 -> 1800 -> outputs 1600, 1700, 1800 on three successive period_starts; 1750 target with slew 100 from 1700 lands exactly on 1750.
- Auto command 2500/500 -> clamped to 2000/1000. Min = 2000, max = 1000 -> both channels output 1000.
- timeout = 3, no commands -> failsafe_o = 1 after the 3rd period_start; outputs return to neutral. A transfer on the same cycle as the 3rd period_start -> no failsafe. A later transfer exits FAILSAFE.
- Assert axi_rst mid-slew -> all outputs 0 immediately. Drop enable_i -> pwm_enable_o = 0 next cycle, both readys 0, outputs at neutral.
